// File: rtl/paddle_ai_driver.sv
// Computer-opponent driver for a Pong paddle: emits one-row-step presses on the
// active-low push1 (up) / push2 (down) lines, tracking the ball or a rest row.
module paddle_ai_driver #(
    parameter int unsigned WAIT_CYCLES  = 2500000,
    parameter int unsigned GAP_CYCLES   = 1,
    parameter int unsigned REACT_CYCLES = 1250000,
    parameter logic [2:0]  REST_ROW     = 3'd3
) (
    input  logic       in_clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] ball_y,
    input  logic       ball_toward,
    input  logic [2:0] y_paddle,
    output logic       push1,
    output logic       push2,
    output logic       busy
);

    localparam int CW = 22;
    localparam logic [CW-1:0] PRESS_LOAD = CW'(WAIT_CYCLES);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] REACT_LOAD = CW'(REACT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECIDE,
        S_REACT,
        S_PRESS,
        S_GAP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dir_up_q, dir_up_d;
    logic            rise_pending_q, rise_pending_d;
    logic            toward_q;
    logic            push1_q, push1_d;
    logic            push2_q, push2_d;
    logic            busy_q, busy_d;

    logic            rise;
    logic            pending;
    logic [2:0]      target;

    // A turn seen this very cycle counts as pending, so DECIDE never presses
    // toward a freshly turned ball before the reaction delay has run.
    assign rise    = ball_toward & ~toward_q;
    assign pending = rise_pending_q | rise;
    assign target  = ball_toward ? ball_y : REST_ROW;

    // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        dir_up_d       = dir_up_q;
        rise_pending_d = pending;

        unique case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_DECIDE;
            end
            S_DECIDE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (pending) begin
                    state_d        = S_REACT;
                    cnt_d          = REACT_LOAD;
                    rise_pending_d = 1'b0;
                end else if (target < y_paddle && y_paddle != 3'd0) begin
                    state_d  = S_PRESS;
                    dir_up_d = 1'b1;
                    cnt_d    = PRESS_LOAD;
                end else if (target > y_paddle && y_paddle != 3'd7) begin
                    state_d  = S_PRESS;
                    dir_up_d = 1'b0;
                    cnt_d    = PRESS_LOAD;
                end
            end
            S_REACT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_DECIDE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_PRESS: begin
                // Held for exactly one step-tick period regardless of enable.
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = enable ? S_DECIDE : S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        push1_d = !(state_d == S_PRESS && dir_up_d);
        push2_d = !(state_d == S_PRESS && !dir_up_d);
        busy_d  = (state_d == S_PRESS) || (state_d == S_GAP);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge in_clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            dir_up_q       <= 1'b0;
            rise_pending_q <= 1'b0;
            toward_q       <= 1'b0;
            push1_q        <= 1'b1;
            push2_q        <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dir_up_q       <= dir_up_d;
            rise_pending_q <= rise_pending_d;
            toward_q       <= ball_toward;
            push1_q        <= push1_d;
            push2_q        <= push2_d;
            busy_q         <= busy_d;
        end
    end

    assign push1 = push1_q;
    assign push2 = push2_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_paddle_ai_driver.sv
// Directed bench for paddle_ai_driver with a behavioural paddle controller
// (row +/-1 on a free-running tick every WAIT+1 cycles).
module tb_paddle_ai_driver;

    localparam int WAIT  = 4;
    localparam int GAP   = 2;
    localparam int REACT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       ball_toward = 1'b0;
    logic [2:0] ball_y = 3'd0;
    logic [2:0] row = 3'd0;
    logic [2:0] row_val = 3'd0;
    logic       row_set = 1'b0;
    logic       push1, push2, busy;

    int tests_run = 0;
    int tests_failed = 0;
    int tick_cnt = 0;
    int p1_lows = 0, p2_lows = 0, both_lows = 0, busy_cycles = 0;

    always #5 clk = ~clk;

    paddle_ai_driver #(
        .WAIT_CYCLES (WAIT),
        .GAP_CYCLES  (GAP),
        .REACT_CYCLES(REACT),
        .REST_ROW    (3'd3)
    ) dut (
        .in_clk     (clk),
        .reset      (reset),
        .enable     (enable),
        .ball_y     (ball_y),
        .ball_toward(ball_toward),
        .y_paddle   (row),
        .push1      (push1),
        .push2      (push2),
        .busy       (busy)
    );

    // Paddle controller model: samples the buttons once per tick.
    always @(posedge clk) begin
        tick_cnt <= (tick_cnt == WAIT) ? 0 : tick_cnt + 1;
        if (row_set) begin
            row <= row_val;
        end else if (tick_cnt == WAIT) begin
            if (!push1)      row <= row - 3'd1;
            else if (!push2) row <= row + 3'd1;
        end
    end

    always @(negedge clk) begin
        if (!push1)           p1_lows     <= p1_lows + 1;
        if (!push2)           p2_lows     <= p2_lows + 1;
        if (!push1 && !push2) both_lows   <= both_lows + 1;
        if (busy)             busy_cycles <= busy_cycles + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input logic [2:0] v);
        row_val = v;
        row_set = 1'b1;
        step();
        row_set = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_low(input bit up, input int budget, output int waited, output bit ok);
        waited = 0;
        while ((up ? push1 : push2) !== 1'b0 && waited < budget) begin
            step();
            waited++;
        end
        ok = ((up ? push1 : push2) === 1'b0);
    endtask

    task automatic count_low(input bit up, output int len);
        len = 0;
        while ((up ? push1 : push2) === 1'b0 && len < 100) begin
            len++;
            step();
        end
    endtask

    task automatic test_reset();
        enable = 1'b0;
        steps(2);
        set_row(3'd3);
        enable = 1'b1;
        ball_y = 3'd6;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (push1 !== 1'b1 || push2 !== 1'b1 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold%0d: got p1=%b p2=%b busy=%b expected 1 1 0", i, push1, push2, busy);
            end
        end
        reset = 1'b0;
        step();
        tests_run++;
        if (push1 !== 1'b1 || push2 !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got p1=%b p2=%b busy=%b expected 1 1 0", push1, push2, busy);
        end
        steps(3);
        tests_run++;
        if (busy !== 1'b0 || push1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL rest_at_row3: got busy=%b p1=%b expected 0 1", busy, push1);
        end
    endtask

    task automatic test_tracking_down();
        int waited, len, p1s;
        bit ok;
        enable = 1'b0;
        steps(15);
        ball_y = 3'd5;
        ball_toward = 1'b1;
        set_row(3'd2);
        p1s = p1_lows;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_low(1'b0, 40, waited, ok);
            tests_run++;
            if (!ok) begin
                tests_failed++;
                $display("FAIL down_start%0d: got no push2 press expected press", i);
            end
            if (i > 0) begin
                tests_run++;
                if (waited != 3) begin
                    tests_failed++;
                    $display("FAIL down_gap%0d: got %0d high cycles expected 3", i, waited);
                end
            end
            count_low(1'b0, len);
            tests_run++;
            if (len != 5) begin
                tests_failed++;
                $display("FAIL down_len%0d: got %0d expected 5", i, len);
            end
        end
        wait_low(1'b0, 30, waited, ok);
        tests_run++;
        if (ok) begin
            tests_failed++;
            $display("FAIL down_extra: got extra press expected none");
        end
        tests_run++;
        if (row !== 3'd5) begin
            tests_failed++;
            $display("FAIL down_row: got %0d expected 5", row);
        end
        tests_run++;
        if (p1_lows != p1s) begin
            tests_failed++;
            $display("FAIL down_push1: got %0d low cycles expected 0", p1_lows - p1s);
        end
    endtask

    task automatic test_return_rest();
        int waited, len, p2s, b;
        bit ok;
        enable = 1'b0;
        ball_toward = 1'b0;
        steps(15);
        set_row(3'd6);
        p2s = p2_lows;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_low(1'b1, 40, waited, ok);
            count_low(1'b1, len);
            tests_run++;
            if (!ok || len != 5) begin
                tests_failed++;
                $display("FAIL up_len%0d: got %0d expected 5", i, len);
            end
        end
        wait_low(1'b1, 30, waited, ok);
        tests_run++;
        if (ok || row !== 3'd3 || p2_lows != p2s) begin
            tests_failed++;
            $display("FAIL rest_end: got row=%0d extra=%b p2lows=%0d expected 3 0 0", row, ok, p2_lows - p2s);
        end
        // Ball at row 0 with paddle at row 0, then target 7 with paddle at 7.
        enable = 1'b0;
        steps(15);
        ball_y = 3'd0;
        set_row(3'd0);
        ball_toward = 1'b1;
        b = busy_cycles;
        enable = 1'b1;
        steps(30);
        tests_run++;
        if (busy_cycles != b || row !== 3'd0) begin
            tests_failed++;
            $display("FAIL edge_row0: got busy=%0d row=%0d expected 0 0", busy_cycles - b, row);
        end
        enable = 1'b0;
        steps(5);
        ball_y = 3'd7;
        set_row(3'd7);
        b = busy_cycles;
        enable = 1'b1;
        steps(30);
        tests_run++;
        if (busy_cycles != b || row !== 3'd7) begin
            tests_failed++;
            $display("FAIL edge_row7: got busy=%0d row=%0d expected 0 7", busy_cycles - b, row);
        end
    endtask

    task automatic test_reaction();
        int waited, len, b, p2s;
        bit ok;
        enable = 1'b0;
        ball_toward = 1'b0;
        steps(15);
        ball_y = 3'd0;
        set_row(3'd3);
        enable = 1'b1;
        steps(3);
        b = busy_cycles;
        p2s = p2_lows;
        ball_toward = 1'b1;
        wait_low(1'b1, 40, waited, ok);
        tests_run++;
        if (!ok || waited != 5) begin
            tests_failed++;
            $display("FAIL react_delay: got %0d cycles expected 5", waited);
        end
        tests_run++;
        if (busy_cycles != b || p2_lows != p2s) begin
            tests_failed++;
            $display("FAIL react_quiet: got busy=%0d p2=%0d expected 0 0", busy_cycles - b, p2_lows - p2s);
        end
        count_low(1'b1, len);
        tests_run++;
        if (len != 5) begin
            tests_failed++;
            $display("FAIL react_press_len: got %0d expected 5", len);
        end
    endtask

    task automatic test_abort();
        int waited, len, g, p1s, p2s, b;
        bit ok;
        enable = 1'b0;
        steps(20);
        ball_y = 3'd5;
        set_row(3'd2);
        enable = 1'b1;
        wait_low(1'b0, 40, waited, ok);
        step();
        enable = 1'b0;
        count_low(1'b0, len);
        tests_run++;
        if (!ok || len + 1 != 5) begin
            tests_failed++;
            $display("FAIL abort_press_len: got %0d expected 5", len + 1);
        end
        g = 0;
        while (busy === 1'b1 && g < 50) begin
            g++;
            step();
        end
        tests_run++;
        if (g != 2) begin
            tests_failed++;
            $display("FAIL abort_gap: got %0d expected 2", g);
        end
        p1s = p1_lows;
        p2s = p2_lows;
        b = busy_cycles;
        steps(30);
        tests_run++;
        if (p1_lows != p1s || p2_lows != p2s || busy_cycles != b || row !== 3'd3) begin
            tests_failed++;
            $display("FAIL abort_idle: got presses=%0d busy=%0d row=%0d expected 0 0 3",
                     (p1_lows - p1s) + (p2_lows - p2s), busy_cycles - b, row);
        end
    endtask

    task automatic test_reset_mid_press();
        int waited;
        bit ok;
        enable = 1'b1;
        wait_low(1'b0, 40, waited, ok);
        steps(2);
        tests_run++;
        if (!ok || push2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL midpress_setup: got p2=%b expected 0", push2);
        end
        reset = 1'b1;
        step();
        tests_run++;
        if (push1 !== 1'b1 || push2 !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midpress_reset: got p1=%b p2=%b busy=%b expected 1 1 0", push1, push2, busy);
        end
        reset = 1'b0;
        enable = 1'b0;
        steps(3);
        tests_run++;
        if (busy !== 1'b0 || push2 !== 1'b1) begin
            tests_failed++;
            $display("FAIL midpress_after: got busy=%b p2=%b expected 0 1", busy, push2);
        end
    endtask

    initial begin
        test_reset();
        test_tracking_down();
        test_return_rest();
        test_reaction();
        test_abort();
        test_reset_mid_press();
        tests_run++;
        if (both_lows != 0) begin
            tests_failed++;
            $display("FAIL both_low: got %0d cycles expected 0", both_lows);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
